// File: rtl/pn_clk_pkg.sv
// Shared types and helpers for the PN ADC clock-enable generator.
// Holds the control FSM encoding and the effective ratio/phase mapping.
package pn_clk_pkg;

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_IDLE   = 2'd1,
    ST_RUN    = 2'd2
  } pn_state_e;

  localparam int unsigned PN_MAXW = 32;

  // Ratios of 0 and 1 both mean "strobe every cycle".
  function automatic logic [PN_MAXW-1:0] pn_eff_n(
    input logic [PN_MAXW-1:0] div
  );
    return (div < PN_MAXW'(2)) ? PN_MAXW'(1) : div;
  endfunction

  // An out-of-range phase falls back to a zero offset.
  function automatic logic [PN_MAXW-1:0] pn_eff_p(
    input logic [PN_MAXW-1:0] div,
    input logic [PN_MAXW-1:0] phase
  );
    logic [PN_MAXW-1:0] n;
    n = pn_eff_n(div);
    return (phase < n) ? phase : '0;
  endfunction

endpackage

// File: rtl/pn_ce_counter.sv
// One strobe channel: modulo-N counter with a registered clock enable.
// Restart loads the phase and suppresses the strobe for that cycle.
module pn_ce_counter #(
  parameter int unsigned W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_restart,
  input  logic         i_run,
  input  logic [W-1:0] i_n,
  input  logic [W-1:0] i_p,
  output logic         o_ce
);

  logic [W-1:0] r_cnt;
  logic         r_ce;
  logic [W-1:0] w_last;
  logic [W-1:0] w_cnt_nxt;

  assign w_last = i_n - W'(1);

  // >= rather than == keeps the counter bounded whatever value it holds.
  assign w_cnt_nxt = (r_cnt >= w_last) ? '0 : r_cnt + W'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_ce  <= 1'b0;
    end else if (i_restart) begin
      r_cnt <= i_p;
      r_ce  <= 1'b0;
    end else if (i_run) begin
      r_cnt <= w_cnt_nxt;
      r_ce  <= (w_cnt_nxt == w_last);
    end else begin
      r_ce  <= 1'b0;
    end
  end

  assign o_ce = r_ce;

endmodule

// File: rtl/pn_adc_clk_en.sv
// Multi-channel clock-enable generator in the AClk domain: settle
// timer, run/idle FSM, shadowed ratio/phase and common restart pulse.
module pn_adc_clk_en
  import pn_clk_pkg::*;
#(
  parameter int unsigned NCH    = 2,
  parameter int unsigned DIVW   = 16,
  parameter int unsigned SETTLE = 1024
) (
  input  logic                AClk,
  input  logic                ARstn,
  input  logic                Run,
  input  logic                Load,
  input  logic [NCH*DIVW-1:0] Div,
  input  logic [NCH*DIVW-1:0] Phase,
  output logic [NCH-1:0]      Ce,
  output logic                Sync,
  output logic                Ready
);

  localparam int unsigned CW = NCH * DIVW;
  localparam int unsigned SW =
    (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

  pn_state_e r_state;
  pn_state_e w_state_nxt;

  logic [SW-1:0] r_settle;
  logic [SW-1:0] w_settle_nxt;
  logic          w_settle_done;

  logic [CW-1:0] r_div;
  logic [CW-1:0] r_ph;
  logic          r_sync;
  logic          r_ready;

  logic w_restart;
  logic w_run;
  logic w_shadow_we;

  assign w_settle_nxt  = r_settle + SW'(1);
  assign w_settle_done = (SETTLE == 0) ||
                         (w_settle_nxt == SW'(SETTLE));

  always_comb begin
    w_state_nxt = r_state;
    w_restart   = 1'b0;
    w_run       = 1'b0;
    w_shadow_we = 1'b0;
    unique case (r_state)
      ST_SETTLE: begin
        if (w_settle_done) w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        w_shadow_we = Load;
        if (Run) begin
          w_state_nxt = ST_RUN;
          w_restart   = 1'b1;
        end
      end
      ST_RUN: begin
        w_shadow_we = Load;
        if (!Run) begin
          w_state_nxt = ST_IDLE;
        end else if (Load) begin
          w_restart = 1'b1;
        end else begin
          w_run = 1'b1;
        end
      end
      default: w_state_nxt = ST_SETTLE;
    endcase
  end

  always_ff @(posedge AClk or negedge ARstn) begin
    if (!ARstn) begin
      r_state  <= ST_SETTLE;
      r_settle <= '0;
      r_sync   <= 1'b0;
      r_ready  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sync   <= w_restart;
      r_ready  <= (w_state_nxt != ST_SETTLE);
      if (r_state == ST_SETTLE && !w_settle_done)
        r_settle <= w_settle_nxt;
    end
  end

  always_ff @(posedge AClk or negedge ARstn) begin
    if (!ARstn) begin
      r_div <= '0;
      r_ph  <= '0;
    end else if (w_shadow_we) begin
      r_div <= Div;
      r_ph  <= Phase;
    end
  end

  // A Load restart must see the new values on the same edge.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [DIVW-1:0] w_div;
    logic [DIVW-1:0] w_ph;
    logic [DIVW-1:0] w_n;
    logic [DIVW-1:0] w_p;

    assign w_div = Load ? Div[i*DIVW +: DIVW]
                        : r_div[i*DIVW +: DIVW];
    assign w_ph  = Load ? Phase[i*DIVW +: DIVW]
                        : r_ph[i*DIVW +: DIVW];
    assign w_n   = DIVW'(pn_eff_n(PN_MAXW'(w_div)));
    assign w_p   = DIVW'(pn_eff_p(PN_MAXW'(w_div),
                                  PN_MAXW'(w_ph)));

    pn_ce_counter #(
      .W (DIVW)
    ) u_cnt (
      .i_clk     (AClk),
      .i_rst_n   (ARstn),
      .i_restart (w_restart),
      .i_run     (w_run),
      .i_n       (w_n),
      .i_p       (w_p),
      .o_ce      (Ce[i])
    );
  end

  assign Sync  = r_sync;
  assign Ready = r_ready;

endmodule

// File: tb/tb_pn_adc_clk_en.sv
// Directed-vector bench for pn_adc_clk_en (2 channels, SETTLE=16).
// Vectors: inputs sampled at an edge, outputs expected in the next cycle.
module tb_pn_adc_clk_en;

  localparam int unsigned NCH    = 2;
  localparam int unsigned DIVW   = 16;
  localparam int unsigned SETTLE = 16;

  logic                AClk = 1'b0;
  logic                ARstn;
  logic                Run;
  logic                Load;
  logic [NCH*DIVW-1:0] Div;
  logic [NCH*DIVW-1:0] Phase;
  logic [NCH-1:0]      Ce;
  logic                Sync;
  logic                Ready;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        run;
    logic        load;
    logic [15:0] d0, d1, p0, p1;
    logic [1:0]  ce;
    logic        sync;
  } vec_t;

  vec_t tv[$];

  pn_adc_clk_en #(
    .NCH    (NCH),
    .DIVW   (DIVW),
    .SETTLE (SETTLE)
  ) dut (
    .AClk  (AClk),
    .ARstn (ARstn),
    .Run   (Run),
    .Load  (Load),
    .Div   (Div),
    .Phase (Phase),
    .Ce    (Ce),
    .Sync  (Sync),
    .Ready (Ready)
  );

  always #5 AClk = ~AClk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge AClk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [1:0] ece,
                     input logic esync, input logic erdy);
    n_vec++;
    if ({Ce, Sync, Ready} !== {ece, esync, erdy}) begin
      n_bad++;
      $display("FAIL %s: got ce=%b sync=%b ready=%b want ce=%b sync=%b ready=%b",
               nm, Ce, Sync, Ready, ece, esync, erdy);
    end
  endtask

  task automatic chk_rng(input string nm, input int act,
                         input int lo, input int hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic add(input logic run, input logic load,
                     input int d0, input int d1,
                     input int p0, input int p1,
                     input logic [1:0] ce, input logic sync);
    vec_t v;
    v.run = run; v.load = load;
    v.d0 = 16'(d0); v.d1 = 16'(d1);
    v.p0 = 16'(p0); v.p1 = 16'(p1);
    v.ce = ce; v.sync = sync;
    tv.push_back(v);
  endtask

  task automatic drive(input logic run, input logic load,
                       input int d0, input int d1);
    Run   = run;
    Load  = load;
    Div   = {16'(d1), 16'(d0)};
    Phase = '0;
  endtask

  initial begin
    int last_ce, n_sync, n_ce_after;

    // Div {4,3}, Phase {0,2}
    add(0, 1, 4, 3, 0, 2, 2'b00, 0);
    add(1, 0, 0, 0, 0, 0, 2'b00, 1);
    add(1, 0, 0, 0, 0, 0, 2'b00, 0);
    add(1, 0, 0, 0, 0, 0, 2'b00, 0);
    add(1, 0, 0, 0, 0, 0, 2'b11, 0);
    add(1, 0, 0, 0, 0, 0, 2'b00, 0);
    add(1, 0, 0, 0, 0, 0, 2'b00, 0);
    add(1, 0, 0, 0, 0, 0, 2'b10, 0);
    add(1, 0, 0, 0, 0, 0, 2'b01, 0);
    add(1, 0, 0, 0, 0, 0, 2'b00, 0);
    add(1, 0, 0, 0, 0, 0, 2'b10, 0);
    add(1, 0, 0, 0, 0, 0, 2'b00, 0);
    add(1, 0, 0, 0, 0, 0, 2'b01, 0);
    add(1, 0, 0, 0, 0, 0, 2'b10, 0);
    add(0, 0, 0, 0, 0, 0, 2'b00, 0);
    add(0, 0, 0, 0, 0, 0, 2'b00, 0);
    // Div {0,1}: strobe every RUN cycle after the restart
    add(0, 1, 0, 1, 0, 0, 2'b00, 0);
    add(1, 0, 0, 0, 0, 0, 2'b00, 1);
    add(1, 0, 0, 0, 0, 0, 2'b11, 0);
    add(1, 0, 0, 0, 0, 0, 2'b11, 0);
    add(0, 0, 0, 0, 0, 0, 2'b00, 0);
    // Load with Run rising; ch0 phase 9 >= 5 acts as 0
    add(1, 1, 5, 2, 9, 1, 2'b00, 1);
    add(1, 0, 0, 0, 0, 0, 2'b00, 0);
    add(1, 0, 0, 0, 0, 0, 2'b10, 0);
    add(1, 0, 0, 0, 0, 0, 2'b00, 0);
    add(1, 0, 0, 0, 0, 0, 2'b11, 0);
    add(1, 0, 0, 0, 0, 0, 2'b00, 0);
    add(1, 0, 0, 0, 0, 0, 2'b10, 0);
    // Load with Run falling: no Sync
    add(0, 1, 4, 2, 0, 0, 2'b00, 0);
    add(1, 0, 0, 0, 0, 0, 2'b00, 1);
    add(1, 0, 0, 0, 0, 0, 2'b10, 0);
    add(1, 0, 0, 0, 0, 0, 2'b00, 0);
    // Load in RUN: restart with ch0 N=7
    add(1, 1, 7, 2, 0, 0, 2'b00, 1);
    add(1, 0, 0, 0, 0, 0, 2'b10, 0);
    add(1, 0, 0, 0, 0, 0, 2'b00, 0);
    add(1, 0, 0, 0, 0, 0, 2'b10, 0);
    add(1, 0, 0, 0, 0, 0, 2'b00, 0);
    add(1, 0, 0, 0, 0, 0, 2'b10, 0);
    add(1, 0, 0, 0, 0, 0, 2'b01, 0);
    add(1, 0, 0, 0, 0, 0, 2'b10, 0);
    add(1, 0, 0, 0, 0, 0, 2'b00, 0);
    add(1, 0, 0, 0, 0, 0, 2'b10, 0);
    add(1, 0, 0, 0, 0, 0, 2'b00, 0);
    add(1, 0, 0, 0, 0, 0, 2'b10, 0);
    add(1, 0, 0, 0, 0, 0, 2'b00, 0);
    add(1, 0, 0, 0, 0, 0, 2'b11, 0);
    add(1, 0, 0, 0, 0, 0, 2'b00, 0);
    add(0, 0, 0, 0, 0, 0, 2'b00, 0);

    // Reset, then settle with Run held high
    ARstn = 1'b0;
    drive(1, 0, 0, 0);
    repeat (3) step();
    chk("reset", 2'b00, 0, 0);
    ARstn = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("settle%0d", k), 2'b00, 0, k == 16);
    end
    step();
    chk("post_settle_sync", 2'b00, 1, 1);
    step();
    chk("div0_run", 2'b11, 0, 1);
    Run = 1'b0;
    step();
    chk("div0_idle", 2'b00, 0, 1);

    for (int i = 0; i < tv.size(); i++) begin
      Run   = tv[i].run;
      Load  = tv[i].load;
      Div   = {tv[i].d1, tv[i].d0};
      Phase = {tv[i].p1, tv[i].p0};
      step();
      chk($sformatf("vec%0d", i), tv[i].ce, tv[i].sync, 1'b1);
    end

    // Ratio 4 -> 7 change mid-period
    drive(0, 1, 4, 4);
    step();
    chk("r47_load", 2'b00, 0, 1);
    drive(1, 0, 0, 0);
    step();
    chk("r47_entry", 2'b00, 1, 1);
    last_ce = -1;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (Ce[0]) last_ce = k;
    end
    chk_rng("r47_first_ce", last_ce, 3, 3);
    drive(1, 1, 7, 7);
    step();
    chk("r47_restart", 2'b00, 1, 1);
    drive(1, 0, 0, 0);
    n_sync = 0;
    n_ce_after = 0;
    for (int k = 7; k <= 30; k++) begin
      step();
      if (Sync) n_sync++;
      if (Ce[0]) begin
        chk_rng($sformatf("r47_gap_at%0d", k), k - last_ce, 4, 1000);
        if (n_ce_after > 0)
          chk_rng($sformatf("r47_per_at%0d", k), k - last_ce, 7, 7);
        n_ce_after++;
        last_ce = k;
      end
    end
    chk_rng("r47_extra_sync", n_sync, 0, 0);
    chk_rng("r47_ce_count", n_ce_after, 3, 3);

    // Asynchronous reset mid-RUN, then full settle again
    drive(0, 1, 0, 0);
    step();
    drive(1, 0, 0, 0);
    step();
    chk("rst_pre_sync", 2'b00, 1, 1);
    step();
    chk("rst_pre_ce", 2'b11, 0, 1);
    #3;
    ARstn = 1'b0;
    #1;
    chk("rst_async", 2'b00, 0, 0);
    Run = 1'b0;
    step();
    ARstn = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("resettle%0d", k), 2'b00, 0, k == 16);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
